// File: rtl/mar_prog_seq.sv
// -----------------------------------------------------------------------------
// mar_prog_seq
//
// SAP-1 memory address register with a built-in program-mode write sequencer.
//
// Run mode (prog=0): the address is loaded from the W bus while nLm is low.
// The RAM is held in read-only mode (nrd=0, nwr=1).
//
// Program mode (prog=1): the address is loaded from the front-panel switches
// on sw_load. Each wr_req starts a write cycle IDLE -> SETUP -> WRITE -> HOLD.
// The cycle gives the RAM one settle cycle and PULSE_W cycles of nwr low.
// It then gives one hold cycle before the sequencer returns to IDLE.
//
// Optional feature macro: MAR_AUTOINC_EN
//   When defined, addr advances by one (mod 2^ADDR_W) at the end of every
//   completed write. wrap pulses on the edge where addr rolls over to 0.
//   When undefined, addr holds after a write and wrap is constant 0.
//
// Parameters:
//   ADDR_W     - address width in bits (>= 1)
//   PULSE_W    - nwr low time in CLK cycles (>= 1)
//   RESET_ADDR - addr value after reset
//
// Ports:
//   CLK      in   system clock, rising edge
//   nCLR     in   asynchronous active-low reset
//   prog     in   1 = program mode, 0 = run mode
//   nLm      in   active-low load of bus_in (run mode only)
//   bus_in   in   address from the W bus
//   sw_addr  in   address from the panel switches
//   sw_load  in   one-cycle pulse, loads sw_addr (program mode, idle only)
//   wr_req   in   one-cycle pulse, starts a RAM write (program mode, idle only)
//   addr     out  registered RAM address
//   nrd      out  registered active-low RAM read enable
//   nwr      out  registered active-low RAM write enable
//   busy     out  high while a write cycle is in progress
//   wr_done  out  one-cycle pulse after a completed write
//   wrap     out  one-cycle pulse when auto-increment rolls over to 0
//
// Every output comes straight from a flop. No input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module mar_prog_seq #(
  parameter int                ADDR_W     = 4,
  parameter int                PULSE_W    = 2,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              CLK,
  input  logic              nCLR,
  input  logic              prog,
  input  logic              nLm,
  input  logic [ADDR_W-1:0] bus_in,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic              sw_load,
  input  logic              wr_req,
  output logic [ADDR_W-1:0] addr,
  output logic              nrd,
  output logic              nwr,
  output logic              busy,
  output logic              wr_done,
  output logic              wrap
);

  // The pulse counter runs 0 .. PULSE_W-1 inside WRITE.
  localparam int CNT_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WRITE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_nrd;
  logic              r_nwr;
  logic              r_busy;
  logic              r_wr_done;

`ifdef MAR_AUTOINC_EN
  logic              r_wrap;
  // The extra MSB of the incremented address is the rollover indicator.
  logic [ADDR_W:0]   w_addr_inc;
  assign w_addr_inc = {1'b0, r_addr} + {{ADDR_W{1'b0}}, 1'b1};
`endif

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_addr    <= RESET_ADDR;
      r_nrd     <= 1'b1;
      r_nwr     <= 1'b1;
      r_busy    <= 1'b0;
      r_wr_done <= 1'b0;
`ifdef MAR_AUTOINC_EN
      r_wrap    <= 1'b0;
`endif
    end else begin
      // Completion and rollover flags are single-cycle pulses by default.
      r_wr_done <= 1'b0;
`ifdef MAR_AUTOINC_EN
      r_wrap    <= 1'b0;
`endif

      if (!prog) begin
        // Run mode. Leaving program mode mid-write aborts the cycle here.
        // No wr_done and no increment are produced.
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
        r_nrd   <= 1'b0;
        r_nwr   <= 1'b1;
        if (!nLm) begin
          r_addr <= bus_in;
        end
      end else begin
        // Program mode. The RAM read enable is off for the whole mode.
        r_nrd <= 1'b1;

        case (r_state)
          ST_IDLE: begin
            r_nwr <= 1'b1;
            // The address load happens before the write request is seen.
            // A coincident sw_load and wr_req therefore write to the new address.
            if (sw_load) begin
              r_addr <= sw_addr;
            end
            if (wr_req) begin
              r_state <= ST_SETUP;
              r_busy  <= 1'b1;
            end
          end

          ST_SETUP: begin
            // nwr is registered. Driving it low on this edge makes it low
            // for exactly the cycles spent in WRITE.
            r_state <= ST_WRITE;
            r_cnt   <= '0;
            r_nwr   <= 1'b0;
          end

          ST_WRITE: begin
            if (r_cnt == CNT_LAST) begin
              r_state <= ST_HOLD;
              r_cnt   <= '0;
              r_nwr   <= 1'b1;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_nwr   <= 1'b0;
            end
          end

          ST_HOLD: begin
            r_state   <= ST_IDLE;
            r_nwr     <= 1'b1;
            r_busy    <= 1'b0;
            r_wr_done <= 1'b1;
`ifdef MAR_AUTOINC_EN
            r_addr    <= w_addr_inc[ADDR_W-1:0];
            r_wrap    <= w_addr_inc[ADDR_W];
`endif
          end

          default: begin
            r_state <= ST_IDLE;
            r_nwr   <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign addr    = r_addr;
  assign nrd     = r_nrd;
  assign nwr     = r_nwr;
  assign busy    = r_busy;
  assign wr_done = r_wr_done;
`ifdef MAR_AUTOINC_EN
  assign wrap    = r_wrap;
`else
  assign wrap    = 1'b0;
`endif

endmodule

// File: tb/tb_mar_prog_seq.sv
// -----------------------------------------------------------------------------
// tb_mar_prog_seq
//
// Scoreboard bench for mar_prog_seq (ADDR_W=4, PULSE_W=2, RESET_ADDR=0).
// Each scenario task queues per-cycle stimulus together with the outputs
// expected after the following rising edge. It then replays the queue and
// checks the observed output vector {addr, nrd, nwr, busy, wr_done, wrap}
// one edge at a time. Inputs change 1 ns after the edge and outputs are
// sampled at the same point.
// -----------------------------------------------------------------------------
module tb_mar_prog_seq;

`ifdef MAR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       CLK;
  logic       nCLR;
  logic       prog;
  logic       nLm;
  logic [3:0] bus_in;
  logic [3:0] sw_addr;
  logic       sw_load;
  logic       wr_req;
  logic [3:0] addr;
  logic       nrd;
  logic       nwr;
  logic       busy;
  logic       wr_done;
  logic       wrap;

  mar_prog_seq #(
    .ADDR_W    (4),
    .PULSE_W   (2),
    .RESET_ADDR(4'h0)
  ) dut (
    .CLK    (CLK),
    .nCLR   (nCLR),
    .prog   (prog),
    .nLm    (nLm),
    .bus_in (bus_in),
    .sw_addr(sw_addr),
    .sw_load(sw_load),
    .wr_req (wr_req),
    .addr   (addr),
    .nrd    (nrd),
    .nwr    (nwr),
    .busy   (busy),
    .wr_done(wr_done),
    .wrap   (wrap)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       prog;
    logic       nlm;
    logic [3:0] bus;
    logic [3:0] swa;
    logic       swl;
    logic       wrq;
  } stim_t;

  stim_t      stim_q[$];
  logic [8:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;

  logic [8:0] w_obs;
  assign w_obs = {addr, nrd, nwr, busy, wr_done, wrap};

  function automatic stim_t st(logic p, logic nl, logic [3:0] b,
                               logic [3:0] sa, logic sl, logic wq);
    stim_t s;
    s.prog = p; s.nlm = nl; s.bus = b; s.swa = sa; s.swl = sl; s.wrq = wq;
    return s;
  endfunction

  function automatic logic [8:0] ev(logic [3:0] a, logic rd, logic wr,
                                    logic bz, logic dn, logic wp);
    return {a, rd, wr, bz, dn, wp};
  endfunction

  function automatic void drive(stim_t s);
    prog = s.prog; nLm = s.nlm; bus_in = s.bus;
    sw_addr = s.swa; sw_load = s.swl; wr_req = s.wrq;
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [8:0] e;
    stim_t s;
    nCLR = 1'b0;
    drive(st(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0));
    #12;
    exp_q.push_back(ev(4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    e = exp_q.pop_front();
    total++;
    if (w_obs !== e) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h", w_obs, e);
    end else $display("reset_state obs=%h", w_obs);
    @(negedge CLK);
    nCLR = 1'b1;
    // The first edge after release applies the run-mode mapping.
    stim_q.push_back(st(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int c = 0; stim_q.size() > 0; c++) begin
      s = stim_q.pop_front();
      drive(s);
      @(posedge CLK); #1;
      e = exp_q.pop_front();
      total++;
      if (w_obs !== e) begin
        bad++;
        $display("FAIL reset_release cyc%0d got=%h exp=%h", c, w_obs, e);
      end else $display("reset_release cyc%0d obs=%h", c, w_obs);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_run_mode();
    logic [8:0] e;
    stim_t s;
    stim_q.push_back(st(1'b0, 1'b0, 4'hA, 4'h0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    stim_q.push_back(st(1'b0, 1'b1, 4'h3, 4'h0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    // Switch load and write request are ignored outside program mode.
    stim_q.push_back(st(1'b0, 1'b1, 4'h3, 4'h7, 1'b1, 1'b1));
    exp_q.push_back(ev(4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    stim_q.push_back(st(1'b0, 1'b1, 4'h3, 4'h7, 1'b0, 1'b0));
    exp_q.push_back(ev(4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int c = 0; stim_q.size() > 0; c++) begin
      s = stim_q.pop_front();
      drive(s);
      @(posedge CLK); #1;
      e = exp_q.pop_front();
      total++;
      if (w_obs !== e) begin
        bad++;
        $display("FAIL run_mode cyc%0d got=%h exp=%h", c, w_obs, e);
      end else $display("run_mode cyc%0d obs=%h", c, w_obs);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_prog_write();
    logic [8:0] e;
    stim_t s;
    logic [3:0] a_after;
    a_after = AUTOINC ? 4'h6 : 4'h5;
    // nLm is low here but must be ignored in program mode.
    stim_q.push_back(st(1'b1, 1'b0, 4'hC, 4'h5, 1'b1, 1'b0));
    exp_q.push_back(ev(4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'hC, 4'h5, 1'b0, 1'b1));
    exp_q.push_back(ev(4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));   // SETUP
    stim_q.push_back(st(1'b1, 1'b1, 4'hC, 4'h5, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));   // WRITE 1
    stim_q.push_back(st(1'b1, 1'b1, 4'hC, 4'h5, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));   // WRITE 2
    stim_q.push_back(st(1'b1, 1'b1, 4'hC, 4'h5, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));   // HOLD
    stim_q.push_back(st(1'b1, 1'b1, 4'hC, 4'h5, 1'b0, 1'b0));
    exp_q.push_back(ev(a_after, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0)); // done
    stim_q.push_back(st(1'b1, 1'b1, 4'hC, 4'h5, 1'b0, 1'b0));
    exp_q.push_back(ev(a_after, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int c = 0; stim_q.size() > 0; c++) begin
      s = stim_q.pop_front();
      drive(s);
      @(posedge CLK); #1;
      e = exp_q.pop_front();
      total++;
      if (w_obs !== e) begin
        bad++;
        $display("FAIL prog_write cyc%0d got=%h exp=%h", c, w_obs, e);
      end else $display("prog_write cyc%0d obs=%h", c, w_obs);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wrap();
    logic [8:0] e;
    stim_t s;
    logic [3:0] a_after;
    a_after = AUTOINC ? 4'h0 : 4'hF;
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'hF, 1'b1, 1'b0));
    exp_q.push_back(ev(4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1));
    exp_q.push_back(ev(4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(ev(4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(ev(4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(ev(4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(ev(a_after, 1'b1, 1'b1, 1'b0, 1'b1, AUTOINC));
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(ev(a_after, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int c = 0; stim_q.size() > 0; c++) begin
      s = stim_q.pop_front();
      drive(s);
      @(posedge CLK); #1;
      e = exp_q.pop_front();
      total++;
      if (w_obs !== e) begin
        bad++;
        $display("FAIL wrap cyc%0d got=%h exp=%h", c, w_obs, e);
      end else $display("wrap cyc%0d obs=%h", c, w_obs);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [8:0] e;
    stim_t s;
    logic [3:0] a_after;
    a_after = AUTOINC ? 4'hA : 4'h9;
    // Coincident load and request: the write uses the freshly loaded 9.
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'h9, 1'b1, 1'b1));
    exp_q.push_back(ev(4'h9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    // Load and request while busy are dropped.
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'h2, 1'b1, 1'b1));
    exp_q.push_back(ev(4'h9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'h2, 1'b1, 1'b1));
    exp_q.push_back(ev(4'h9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'h2, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'h2, 1'b1, 1'b1));  // seen in HOLD
    exp_q.push_back(ev(a_after, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'h2, 1'b0, 1'b0));
    exp_q.push_back(ev(a_after, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'h2, 1'b0, 1'b0));
    exp_q.push_back(ev(a_after, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int c = 0; stim_q.size() > 0; c++) begin
      s = stim_q.pop_front();
      drive(s);
      @(posedge CLK); #1;
      e = exp_q.pop_front();
      total++;
      if (w_obs !== e) begin
        bad++;
        $display("FAIL back_to_back cyc%0d got=%h exp=%h", c, w_obs, e);
      end else $display("back_to_back cyc%0d obs=%h", c, w_obs);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_abort();
    logic [8:0] e;
    stim_t s;
    stim_q.push_back(st(1'b1, 1'b1, 4'hE, 4'h3, 1'b1, 1'b0));
    exp_q.push_back(ev(4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'hE, 4'h3, 1'b0, 1'b1));
    exp_q.push_back(ev(4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'hE, 4'h3, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    stim_q.push_back(st(1'b0, 1'b1, 4'hE, 4'h3, 1'b0, 1'b0));  // prog falls
    exp_q.push_back(ev(4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    stim_q.push_back(st(1'b0, 1'b1, 4'hE, 4'h3, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'hE, 4'h3, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'hE, 4'h3, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int c = 0; stim_q.size() > 0; c++) begin
      s = stim_q.pop_front();
      drive(s);
      @(posedge CLK); #1;
      e = exp_q.pop_front();
      total++;
      if (w_obs !== e) begin
        bad++;
        $display("FAIL abort cyc%0d got=%h exp=%h", c, w_obs, e);
      end else $display("abort cyc%0d obs=%h", c, w_obs);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_async_reset();
    logic [8:0] e;
    stim_t s;
    logic [3:0] a_after;
    a_after = AUTOINC ? 4'h1 : 4'h0;
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'h7, 1'b1, 1'b0));
    exp_q.push_back(ev(4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'h7, 1'b0, 1'b1));
    exp_q.push_back(ev(4'h7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'h7, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int c = 0; stim_q.size() > 0; c++) begin
      s = stim_q.pop_front();
      drive(s);
      @(posedge CLK); #1;
      e = exp_q.pop_front();
      total++;
      if (w_obs !== e) begin
        bad++;
        $display("FAIL async_pre cyc%0d got=%h exp=%h", c, w_obs, e);
      end else $display("async_pre cyc%0d obs=%h", c, w_obs);
    end
    // In WRITE with nwr low. Pulse nCLR between edges.
    #1 nCLR = 1'b0;
    #1;
    exp_q.push_back(ev(4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    e = exp_q.pop_front();
    total++;
    if (w_obs !== e) begin
      bad++;
      $display("FAIL async_reset got=%h exp=%h", w_obs, e);
    end else $display("async_reset obs=%h", w_obs);
    #1 nCLR = 1'b1;
    // The next edge must find the sequencer in IDLE, ready for a new write.
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'h7, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'h7, 1'b0, 1'b1));
    exp_q.push_back(ev(4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'h7, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'h7, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'h7, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    stim_q.push_back(st(1'b1, 1'b1, 4'h0, 4'h7, 1'b0, 1'b0));
    exp_q.push_back(ev(a_after, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    for (int c = 0; stim_q.size() > 0; c++) begin
      s = stim_q.pop_front();
      drive(s);
      @(posedge CLK); #1;
      e = exp_q.pop_front();
      total++;
      if (w_obs !== e) begin
        bad++;
        $display("FAIL async_post cyc%0d got=%h exp=%h", c, w_obs, e);
      end else $display("async_post cyc%0d obs=%h", c, w_obs);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_run_mode();
    test_prog_write();
    test_wrap();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
